dac_spi_tx: RTL

Serial transmitter that drives the MCP4911 10-bit SPI DAC from the audio processing path. It accepts a 10-bit offset-binary sample, already including DAC_OFFSET, together with a load strobe. It then shifts a 16-bit write frame out on SPI mode 0 and pulses LDAC_n so the DAC output updates. It sits downstream of the echo/delay processors and is the output-side counterpart of the ADC sampling front end that produces data_in and valid.

---
 rtl/dac_pkg.sv | 7 +
 rtl/dac_spi_tx_tick_gen.sv | 19 +
 rtl/dac_spi_tx.sv | 107 ++++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// dac_pkg: shared FSM state type and frame constants for the MCP4911 SPI transmitter.
package dac_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, CS_HIGH, LDAC} state_e;
    localparam int FRAME_BITS = 16;
    localparam int SHIFT_HALVES = 32;
    localparam logic [3:0] CFG_BITS_DEFAULT = 4'b0111;
endpackage

// File: rtl/dac_spi_tx_tick_gen.sv
// tick_gen: CLK_DIV clock-enable divider with a synchronous clear used at frame start.
module tick_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
    logic [7:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? 8'd0 : !en ? cnt_q : (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
    assign tick = en && !clr && (cnt_q == LAST);
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: shifts {CFG_BITS, sample, 2'b00} to an MCP4911 on SPI mode 0, then pulses LDAC_n.
module dac_spi_tx import dac_pkg::*; #(
    parameter int         CLK_DIV  = 25,
    parameter logic [3:0] CFG_BITS = CFG_BITS_DEFAULT
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [9:0] data_in,
    output logic       dac_cs_n,
    output logic       dac_sck,
    output logic       dac_sdi,
    output logic       dac_ld_n,
    output logic       busy,
    output logic       done
);
    localparam logic [5:0] LAST_HALF = 6'(SHIFT_HALVES);
    localparam logic [5:0] LAST_SHIFT = 6'(SHIFT_HALVES - 1);
    state_e                state_q, state_d;
    logic [5:0]            half_q, half_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic                  pend_q, pend_d;
    logic [9:0]            pbuf_q, pbuf_d;
    logic                  cs_n_q, cs_n_d, sck_q, sck_d, sdi_q, sdi_d;
    logic                  ld_n_q, ld_n_d, busy_q, busy_d, done_q, done_d;
    logic                  start, tick;
    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .en    (state_q != IDLE),
        .clr   (start),
        .tick  (tick)
    );
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        sr_d    = sr_q;
        start   = 1'b0;
        // Any load not consumed by a frame start lands in the one-deep buffer.
        pend_d  = pend_q || load;
        pbuf_d  = load ? data_in : pbuf_q;
        case (state_q)
            IDLE: if (load || pend_q) begin
                start   = 1'b1;
                state_d = SETUP;
                half_d  = 6'd0;
                sr_d    = {CFG_BITS, pend_q ? pbuf_q : data_in, 2'b00};
                pend_d  = pend_q && load;
            end
            SETUP: if (tick) begin
                state_d = SHIFT;
                half_d  = 6'd1;
            end
            SHIFT: if (tick) begin
                half_d  = half_q + 6'd1;
                state_d = (half_q == LAST_HALF) ? CS_HIGH : SHIFT;
                // Advance on falling SCK, except the final fall where bit 0 is held.
                if (half_q[0] && half_q != LAST_SHIFT) sr_d = sr_q << 1;
            end
            CS_HIGH: if (tick) begin
                state_d = LDAC;
                half_d  = half_q + 6'd1;
            end
            LDAC: if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cs_n_d = !(state_d == SETUP || state_d == SHIFT);
        sck_d  = (state_d == SHIFT) && half_d[0];
        sdi_d  = !cs_n_d && sr_d[FRAME_BITS-1];
        ld_n_d = state_d != LDAC;
        busy_d = state_d != IDLE;
        done_d = (state_q == LDAC) && tick;
    end
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            half_q  <= 6'd0;
            sr_q    <= '0;
            pend_q  <= 1'b0;
            pbuf_q  <= 10'd0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
            ld_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            sr_q    <= sr_d;
            pend_q  <= pend_d;
            pbuf_q  <= pbuf_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            sdi_q   <= sdi_d;
            ld_n_q  <= ld_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign dac_cs_n = cs_n_q;
    assign dac_sck  = sck_q;
    assign dac_sdi  = sdi_q;
    assign dac_ld_n = ld_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule
